// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the APB requester bridge toward the SPI register window.
package apb_master_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } state_e;

  // Upper 20 address bits of the SPI peripheral register window (0x4000_2xxx).
  localparam logic [19:0] SpiRegBase = 20'h40002;

  localparam int unsigned DefAddrW    = 32;
  localparam int unsigned DefDataW    = 32;
  localparam int unsigned DefTimeout  = 16;
  localparam int unsigned DefToCntW   = 5;

  function automatic logic in_spi_window(input logic [31:0] addr);
    return addr[31:12] == SpiRegBase;
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response and APB signals of the bridge; master = bridge view, slave = the other side.
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_write;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [DATA_W-1:0] i_cmd_wdata;

  logic              o_rsp_valid;
  logic [DATA_W-1:0] o_rsp_rdata;
  logic              o_rsp_err;
  logic              o_rsp_timeout;

  logic              o_psel;
  logic              o_penable;
  logic              o_pwrite;
  logic [ADDR_W-1:0] o_paddr;
  logic [DATA_W-1:0] o_pwdata;
  logic [DATA_W-1:0] i_prdata;
  logic              i_pready;
  logic              i_pslverr;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata,
    output o_cmd_ready,
    output o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
    input  i_prdata, i_pready, i_pslverr
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata,
    input  o_cmd_ready,
    input  o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
    output i_prdata, i_pready, i_pslverr
  );

endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// Counts ACCESS cycles spent waiting on PREADY; flags the cycle on which the wait limit is hit.
module apb_master_bridge_wait_timer #(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned TO_CNT_W = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // The current waited cycle is the TIMEOUT-th one when the count so far is TIMEOUT-1.
  localparam logic [TO_CNT_W-1:0] Limit = TO_CNT_W'(TIMEOUT - 1);

  logic [TO_CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != {TO_CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && enable_i && (count_q == Limit);

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns single commands into SETUP/ACCESS transfers with a wait-state timeout.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned TIMEOUT  = DefTimeout,
  parameter int unsigned TO_CNT_W = DefToCntW
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  apb_master_bridge_if.master bus
);

  state_e state_q, state_d;

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  assign timer_en = (state_q == StAccess) && !bus.i_pready;

  apb_master_bridge_wait_timer #(
    .TIMEOUT  (TIMEOUT),
    .TO_CNT_W (TO_CNT_W)
  ) u_wait_timer (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    timer_clear   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_cmd_valid) begin
          pwrite_d    = bus.i_cmd_write;
          paddr_d     = bus.i_cmd_addr;
          pwdata_d    = bus.i_cmd_wdata;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          timer_clear = 1'b1;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        // A PREADY on the limit cycle completes normally, so it is tested first.
        if (bus.i_pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.i_prdata;
          rsp_err_d     = bus.i_pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = StIdle;
        end else if (timer_expired) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = StIdle;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.o_cmd_ready   = (state_q == StIdle);
  assign bus.o_psel        = psel_q;
  assign bus.o_penable     = penable_q;
  assign bus.o_pwrite      = pwrite_q;
  assign bus.o_paddr       = paddr_q;
  assign bus.o_pwdata      = pwdata_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_rdata   = rsp_rdata_q;
  assign bus.o_rsp_err     = rsp_err_q;
  assign bus.o_rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench: a per-transfer schedule model checks every output on every falling edge.
module tb_apb_master_bridge;
  import apb_master_bridge_pkg::*;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned TO_CNT_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_bridge #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TIMEOUT  (TIMEOUT),
    .TO_CNT_W (TO_CNT_W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the transfer in flight, expressed as a cycle schedule from its handshake cycle.
  bit          tx_on = 1'b0;
  int          tx_n = 0;
  int          tx_a = 0;
  bit          tx_w = 1'b0;
  logic [31:0] tx_addr = '0, tx_wdata = '0, tx_rd = '0;
  bit          tx_err = 1'b0, tx_to = 1'b0;
  bit          hold_w = 1'b0;
  logic [31:0] hold_addr = '0, hold_wdata = '0;
  logic [31:0] last_rd = '0;
  bit          last_err = 1'b0, last_to = 1'b0;
  bit          busy, exp_valid;
  int          rsp_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      tx_on = 1'b0;
      hold_w = 1'b0; hold_addr = '0; hold_wdata = '0;
      last_rd = '0; last_err = 1'b0; last_to = 1'b0;
      busy = 1'b0;
      exp_valid = 1'b0;
    end else begin
      busy      = tx_on && (cyc >= tx_n + 1) && (cyc <= tx_n + 1 + tx_a);
      exp_valid = tx_on && (cyc == tx_n + 2 + tx_a);
      if (tx_on && cyc >= tx_n + 1) begin
        hold_w = tx_w; hold_addr = tx_addr; hold_wdata = tx_wdata;
      end
      if (exp_valid) begin
        last_rd = tx_rd; last_err = tx_err; last_to = tx_to;
        tx_on = 1'b0;
      end
    end
    if (bus.o_rsp_valid) rsp_cyc = cyc;
    chk("cmd_ready", 64'(bus.o_cmd_ready), 64'(!busy));
    chk("psel", 64'(bus.o_psel), 64'(busy));
    chk("penable", 64'(bus.o_penable), 64'(busy && (cyc >= tx_n + 2)));
    chk("pwrite", 64'(bus.o_pwrite), 64'(hold_w));
    chk("paddr", 64'(bus.o_paddr), 64'(hold_addr));
    chk("pwdata", 64'(bus.o_pwdata), 64'(hold_wdata));
    chk("rsp_valid", 64'(bus.o_rsp_valid), 64'(exp_valid));
    chk("rsp_rdata", 64'(bus.o_rsp_rdata), 64'(last_rd));
    chk("rsp_err", 64'(bus.o_rsp_err), 64'(last_err));
    chk("rsp_timeout", 64'(bus.o_rsp_timeout), 64'(last_to));
  end

  // Issue one command and play the slave: PREADY rises after `waits` low ACCESS cycles.
  task automatic do_xfer(input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic [31:0] rd, input bit se);
    int acc;
    rsp_cyc = -1;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b1; bus.i_cmd_write = w; bus.i_cmd_addr = a; bus.i_cmd_wdata = wd;
    acc      = (waits < int'(TIMEOUT)) ? waits + 1 : int'(TIMEOUT);
    tx_n     = cyc;
    tx_a     = acc;
    tx_w     = w;
    tx_addr  = a;
    tx_wdata = wd;
    tx_to    = (waits >= int'(TIMEOUT));
    tx_err   = tx_to || se;
    tx_rd    = (w || tx_to) ? 32'h0 : rd;
    tx_on    = 1'b1;
    @(posedge clk); #1;
    // Conflicting command held during the transfer must be ignored.
    bus.i_cmd_write = ~w; bus.i_cmd_addr = ~a; bus.i_cmd_wdata = ~wd;
    for (int j = 0; j < acc; j++) begin
      @(posedge clk); #1;
      bus.i_pready  = (j == waits);
      bus.i_prdata  = (j == waits) ? rd : $urandom;
      bus.i_pslverr = (j == waits) ? se : 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0; bus.i_pready = 1'b0; bus.i_pslverr = 1'b1; bus.i_prdata = $urandom;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n;
    bus.i_cmd_valid = 1'b0; bus.i_cmd_write = 1'b0; bus.i_cmd_addr = '0; bus.i_cmd_wdata = '0;
    bus.i_prdata = '0; bus.i_pready = 1'b0; bus.i_pslverr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Zero-wait write.
    do_xfer(1'b1, 32'h4000_2004, 32'hA5A5_0001, 0, 32'hDEAD_BEEF, 1'b0);
    chk("wr_latency", 64'(rsp_cyc - tx_n), 64'd3);
    chk("wr_rdata", 64'(bus.o_rsp_rdata), 64'h0);
    chk("wr_err", 64'(bus.o_rsp_err), 64'h0);
    chk("wr_window", 64'(in_spi_window(bus.o_paddr)), 64'h1);

    // Read with three wait states.
    do_xfer(1'b0, 32'h4000_2008, 32'h0, 3, 32'h1234_5678, 1'b0);
    chk("rd_latency", 64'(rsp_cyc - tx_n), 64'd6);
    chk("rd_rdata", 64'(bus.o_rsp_rdata), 64'h1234_5678);

    // Slave error on a read.
    do_xfer(1'b0, 32'h4000_2020, 32'h0, 1, 32'h0000_00C3, 1'b1);
    chk("slverr_err", 64'(bus.o_rsp_err), 64'h1);
    chk("slverr_timeout", 64'(bus.o_rsp_timeout), 64'h0);

    // PREADY never arrives: abort after 16 ACCESS cycles.
    do_xfer(1'b0, 32'h4000_2010, 32'h0, 100, 32'h5555_AAAA, 1'b0);
    chk("to_latency", 64'(rsp_cyc - tx_n), 64'd18);
    chk("to_err", 64'(bus.o_rsp_err), 64'h1);
    chk("to_timeout", 64'(bus.o_rsp_timeout), 64'h1);
    chk("to_rdata", 64'(bus.o_rsp_rdata), 64'h0);
    chk("to_psel", 64'(bus.o_psel), 64'h0);

    // PREADY on the limit cycle completes normally.
    do_xfer(1'b0, 32'h4000_2014, 32'h0, 15, 32'h0BAD_F00D, 1'b0);
    chk("edge_latency", 64'(rsp_cyc - tx_n), 64'd18);
    chk("edge_timeout", 64'(bus.o_rsp_timeout), 64'h0);
    chk("edge_err", 64'(bus.o_rsp_err), 64'h0);
    chk("edge_rdata", 64'(bus.o_rsp_rdata), 64'h0BAD_F00D);

    // Reset during ACCESS.
    rsp_cyc = -1;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b1; bus.i_cmd_write = 1'b1;
    bus.i_cmd_addr = 32'h4000_2030; bus.i_cmd_wdata = 32'h7777_0000;
    n = cyc;
    tx_n = n; tx_a = int'(TIMEOUT); tx_w = 1'b1; tx_addr = 32'h4000_2030;
    tx_wdata = 32'h7777_0000; tx_to = 1'b1; tx_err = 1'b1; tx_rd = '0; tx_on = 1'b1;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_psel", 64'(bus.o_psel), 64'h0);
    chk("rst_penable", 64'(bus.o_penable), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_rsp", 64'(rsp_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_cmd_ready", 64'(bus.o_cmd_ready), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
